// File: rtl/i2c_defs.sv
// Shared definitions for the I2C receive byte buffer: FSM codes, default depth, entry packing.
package i2c_defs;

    typedef enum logic [1:0] {
        RXB_IDLE    = 2'd0,
        RXB_CAPTURE = 2'd1,
        RXB_ERROR   = 2'd2
    } rxb_state_e;

    localparam int RXB_DEFAULT_DEPTH = 8;
    localparam int RXB_ENTRY_W       = 16;

    function automatic logic [RXB_ENTRY_W-1:0] pack_entry(input logic [7:0] addr,
                                                         input logic [7:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/i2c_rx_fifo_mem.sv
// DEPTH x W register array with one synchronous write port and one asynchronous read port.
module i2c_rx_fifo_mem
    import i2c_defs::*;
#(
    parameter int DEPTH = RXB_DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = RXB_ENTRY_W
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/i2c_rx_byte_buffer.sv
// Frame-aware FIFO for bytes read by the I2C master; first-word fall-through valid/ready output.
// Optional checksum output enabled by defining I2C_RXBUF_CHKSUM_EN.
module i2c_rx_byte_buffer
    import i2c_defs::*;
#(
    parameter int DEPTH = RXB_DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   i_clk10MHz,
    input  logic                   i_RST_n,
    input  logic                   i_Frame_Start,
    input  logic                   i_Frame_Done,
    input  logic                   i_Byte_Valid,
    input  logic [7:0]             i_Byte,
    input  logic [7:0]             i_Addr,
    input  logic                   i_Err_Flag,
    output logic [RXB_ENTRY_W-1:0] o_Data,
    output logic                   o_Data_Valid,
    input  logic                   i_Data_Ready,
    output logic [AW:0]            o_Count,
    output logic                   o_Full,
    output logic                   o_Empty,
    output logic                   o_Overflow,
    output logic                   o_Frame_Err,
`ifdef I2C_RXBUF_CHKSUM_EN
    output logic [7:0]             o_Chksum,
`endif
    output logic                   o_Frame_Ok
);

    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    rxb_state_e    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          frame_err_q, frame_err_d;
    logic          frame_ok_q, frame_ok_d;
    logic          full, empty, pop, accept, push, drop;

    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign pop    = !empty && i_Data_Ready;
    // A byte arriving together with an error strobe belongs to a failed transfer.
    assign accept = (state_q == RXB_CAPTURE) && i_Byte_Valid && !i_Err_Flag;
    assign push   = accept && (!full || pop);
    assign drop   = accept && full && !pop;

    i2c_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (RXB_ENTRY_W)
    ) u_mem (
        .clk_i   (i_clk10MHz),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (pack_entry(i_Addr, i_Byte)),
        .raddr_i (rd_ptr_q),
        .rdata_o (o_Data)
    );

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // A new Start always re-enters capture and opens a clean frame, whatever state it meets.
    always_comb begin
        state_d     = state_q;
        overflow_d  = overflow_q | drop;
        frame_err_d = frame_err_q;
        frame_ok_d  = 1'b0;
        if (i_Frame_Start) begin
            state_d     = RXB_CAPTURE;
            overflow_d  = 1'b0;
            frame_err_d = 1'b0;
        end else begin
            unique case (state_q)
                RXB_IDLE: begin
                    state_d = RXB_IDLE;
                end
                RXB_CAPTURE: begin
                    if (i_Err_Flag) begin
                        frame_err_d = 1'b1;
                        state_d     = i_Frame_Done ? RXB_IDLE : RXB_ERROR;
                    end else if (i_Frame_Done) begin
                        state_d    = RXB_IDLE;
                        frame_ok_d = !overflow_d && !frame_err_q;
                    end
                end
                RXB_ERROR: begin
                    if (i_Frame_Done) begin
                        state_d = RXB_IDLE;
                    end
                end
                default: state_d = RXB_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk10MHz or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q     <= RXB_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            frame_ok_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            frame_ok_q  <= frame_ok_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

`ifdef I2C_RXBUF_CHKSUM_EN
    logic [7:0] chksum_q, chksum_d;

    always_comb begin
        chksum_d = chksum_q;
        if (i_Frame_Start) begin
            chksum_d = 8'h00;
        end else if (push) begin
            chksum_d = chksum_q ^ i_Byte;
        end
    end

    always_ff @(posedge i_clk10MHz or negedge i_RST_n) begin
        if (!i_RST_n) begin
            chksum_q <= 8'h00;
        end else begin
            chksum_q <= chksum_d;
        end
    end

    assign o_Chksum = chksum_q;
`endif

    assign o_Data_Valid = !empty;
    assign o_Count      = count_q;
    assign o_Full       = full;
    assign o_Empty      = empty;
    assign o_Overflow   = overflow_q;
    assign o_Frame_Err  = frame_err_q;
    assign o_Frame_Ok   = frame_ok_q;

endmodule

// File: tb/tb_i2c_rx_byte_buffer.sv
// Self-checking bench for i2c_rx_byte_buffer: queue-based frame model plus directed literal checks.
module tb_i2c_rx_byte_buffer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_Frame_Start = 1'b0, i_Frame_Done = 1'b0, i_Byte_Valid = 1'b0;
    logic [7:0]  i_Byte = 8'h00, i_Addr = 8'h00;
    logic        i_Err_Flag = 1'b0, i_Data_Ready = 1'b0;
    logic [15:0] o_Data;
    logic        o_Data_Valid, o_Full, o_Empty, o_Overflow, o_Frame_Err, o_Frame_Ok;
    logic [AW:0] o_Count;
`ifdef I2C_RXBUF_CHKSUM_EN
    logic [7:0]  o_Chksum;
`endif

    int vectors = 0;
    int miscompares = 0;
    bit checkEn = 1'b0;

    logic [15:0] mq[$];
    bit          mInCapture, mInError, mOvf, mErr, mOk;
    logic [7:0]  mSum;

    always #50 clk = ~clk;

    i2c_rx_byte_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .i_clk10MHz    (clk),
        .i_RST_n       (rst_n),
        .i_Frame_Start (i_Frame_Start),
        .i_Frame_Done  (i_Frame_Done),
        .i_Byte_Valid  (i_Byte_Valid),
        .i_Byte        (i_Byte),
        .i_Addr        (i_Addr),
        .i_Err_Flag    (i_Err_Flag),
        .o_Data        (o_Data),
        .o_Data_Valid  (o_Data_Valid),
        .i_Data_Ready  (i_Data_Ready),
        .o_Count       (o_Count),
        .o_Full        (o_Full),
        .o_Empty       (o_Empty),
        .o_Overflow    (o_Overflow),
        .o_Frame_Err   (o_Frame_Err),
`ifdef I2C_RXBUF_CHKSUM_EN
        .o_Chksum      (o_Chksum),
`endif
        .o_Frame_Ok    (o_Frame_Ok)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mInCapture = 1'b0;
        mInError   = 1'b0;
        mOvf       = 1'b0;
        mErr       = 1'b0;
        mOk        = 1'b0;
        mSum       = 8'h00;
    endtask

    // Frame rules expressed on a queue: pop first, then a byte fits if the queue has room.
    task automatic modelStep(input bit s, input bit d, input bit bv, input logic [7:0] a,
                             input logic [7:0] b, input bit e, input bit r);
        bit capNow;
        capNow = mInCapture;
        mOk = 1'b0;
        if (mq.size() != 0 && r) void'(mq.pop_front());
        if (capNow && bv && !e) begin
            if (mq.size() < DEPTH) begin
                mq.push_back({a, b});
                mSum = mSum ^ b;
            end else begin
                mOvf = 1'b1;
            end
        end
        if (s) begin
            mInCapture = 1'b1;
            mInError   = 1'b0;
            mOvf       = 1'b0;
            mErr       = 1'b0;
            mSum       = 8'h00;
        end else if (capNow) begin
            if (e) begin
                mErr       = 1'b1;
                mInCapture = 1'b0;
                mInError   = !d;
            end else if (d) begin
                mInCapture = 1'b0;
                mOk        = !mOvf && !mErr;
            end
        end else if (mInError && d) begin
            mInError = 1'b0;
        end
    endtask

    task automatic applyStimulus(input bit s, input bit d, input bit bv, input logic [7:0] a,
                                 input logic [7:0] b, input bit e, input bit r);
        @(negedge clk);
        #1;
        i_Frame_Start = s;
        i_Frame_Done  = d;
        i_Byte_Valid  = bv;
        i_Addr        = a;
        i_Byte        = b;
        i_Err_Flag    = e;
        i_Data_Ready  = r;
        @(posedge clk);
        modelStep(s, d, bv, a, b, e, r);
        #1;
    endtask

    task automatic idle(input int n, input bit r);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, r);
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("valid", 32'(o_Data_Valid), (mq.size() != 0) ? 32'd1 : 32'd0);
            if (mq.size() != 0) checkOutput("data", 32'(o_Data), 32'(mq[0]));
            checkOutput("count", 32'(o_Count), 32'(mq.size()));
            checkOutput("full", 32'(o_Full), (mq.size() == DEPTH) ? 32'd1 : 32'd0);
            checkOutput("empty", 32'(o_Empty), (mq.size() == 0) ? 32'd1 : 32'd0);
            checkOutput("overflow", 32'(o_Overflow), 32'(mOvf));
            checkOutput("frame_err", 32'(o_Frame_Err), 32'(mErr));
            checkOutput("frame_ok", 32'(o_Frame_Ok), 32'(mOk));
`ifdef I2C_RXBUF_CHKSUM_EN
            checkOutput("chksum", 32'(o_Chksum), 32'(mSum));
`endif
        end
    end

    initial begin
        modelReset();
        #5 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_empty", 32'(o_Empty), 32'd1);
        checkOutput("rst_count", 32'(o_Count), 32'd0);
        checkOutput("rst_valid", 32'(o_Data_Valid), 32'd0);
        checkOutput("rst_full", 32'(o_Full), 32'd0);
        checkOutput("rst_ovf", 32'(o_Overflow), 32'd0);
        checkOutput("rst_ferr", 32'(o_Frame_Err), 32'd0);
        checkOutput("rst_ok", 32'(o_Frame_Ok), 32'd0);
        rst_n = 1'b1;
        checkEn = 1'b1;

        // Byte strobes outside a frame are ignored
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h01, 8'hEE, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h02, 8'hEF, 1'b0, 1'b0);
        checkOutput("idle_empty", 32'(o_Empty), 32'd1);

        // Three-byte frame drained as it arrives
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h08, 8'h55, 1'b0, 1'b1);
        checkOutput("f1_head0", 32'(o_Data), 32'h0855);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h09, 8'h56, 1'b0, 1'b1);
        checkOutput("f1_head1", 32'(o_Data), 32'h0956);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h0A, 8'h57, 1'b0, 1'b1);
        checkOutput("f1_head2", 32'(o_Data), 32'h0A57);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        checkOutput("f1_ok", 32'(o_Frame_Ok), 32'd1);
        checkOutput("f1_count", 32'(o_Count), 32'd0);
        idle(1, 1'b1);
        checkOutput("f1_ok_pulse", 32'(o_Frame_Ok), 32'd0);

        // Nine bytes into eight entries with the consumer stalled
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h20 + i), 8'(8'h10 + i), 1'b0, 1'b0);
        checkOutput("ovf_count", 32'(o_Count), 32'd8);
        checkOutput("ovf_full", 32'(o_Full), 32'd1);
        checkOutput("ovf_flag", 32'(o_Overflow), 32'd1);
        checkOutput("ovf_head", 32'(o_Data), 32'h2010);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("ovf_no_ok", 32'(o_Frame_Ok), 32'd0);

        // New frame keeps the full FIFO; push with a same-cycle pop is accepted
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("pp_ovf_clr", 32'(o_Overflow), 32'd0);
        checkOutput("pp_kept", 32'(o_Count), 32'd8);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h30, 8'hAA, 1'b0, 1'b1);
        checkOutput("pp_count", 32'(o_Count), 32'd8);
        checkOutput("pp_ovf", 32'(o_Overflow), 32'd0);
        checkOutput("pp_head", 32'(o_Data), 32'h2111);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("pp_ok", 32'(o_Frame_Ok), 32'd1);
        idle(7, 1'b1);
        checkOutput("pp_last", 32'(o_Data), 32'h30AA);
        checkOutput("pp_last_cnt", 32'(o_Count), 32'd1);
        idle(1, 1'b1);
        checkOutput("pp_drained", 32'(o_Empty), 32'd1);

        // Error mid-frame, then Start from the error state
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h40, 8'h01, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h41, 8'h02, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h42, 8'h03, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h43, 8'h04, 1'b0, 1'b0);
        checkOutput("err_flag", 32'(o_Frame_Err), 32'd1);
        checkOutput("err_count", 32'(o_Count), 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("err_clr", 32'(o_Frame_Err), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h44, 8'h05, 1'b0, 1'b0);
        checkOutput("err_recap", 32'(o_Count), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("err_ok", 32'(o_Frame_Ok), 32'd1);
        idle(3, 1'b1);
        checkOutput("err_drained", 32'(o_Empty), 32'd1);

        // Start and Done together: Start wins
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h50, 8'h66, 1'b0, 1'b0);
        checkOutput("sd_count", 32'(o_Count), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        idle(2, 1'b1);

`ifdef I2C_RXBUF_CHKSUM_EN
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h60, 8'h0F, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h61, 8'hF0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h62, 8'h33, 1'b0, 1'b1);
        checkOutput("cs_value", 32'(o_Chksum), 32'hCC);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        checkOutput("cs_held", 32'(o_Chksum), 32'hCC);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        checkOutput("cs_clr", 32'(o_Chksum), 32'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        idle(2, 1'b1);
`endif

        // Reset in the middle of a frame discards held bytes at once
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h70, 8'h11, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h71, 8'h22, 1'b0, 1'b0);
        #10 rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("mrst_count", 32'(o_Count), 32'd0);
        checkOutput("mrst_empty", 32'(o_Empty), 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h72, 8'h33, 1'b0, 1'b0);
        checkOutput("mrst_idle", 32'(o_Count), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h73, 8'h44, 1'b0, 1'b0);
        checkOutput("mrst_head", 32'(o_Data), 32'h7344);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        idle(2, 1'b1);

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
